// File: rtl/ekf_pkg.sv
// Shared definitions for the EKF step controller: widths, FSM encoding and
// the Q7.8 saturation limits used when narrowing the fused datapath results.
// No ports; imported by ekf_step_ctrl and q_sat_round.
package ekf_pkg;

  localparam int unsigned Q_W     = 16;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned N_STATE = 6;
  localparam int unsigned N_MEAS  = 3;

  localparam int unsigned MEAS_W = N_MEAS * Q_W;
  localparam int unsigned VEC_W  = N_STATE * Q_W;
  localparam int unsigned ACCV_W = N_STATE * ACC_W;

  // Saturation limits: state lanes are full signed range, covariance lanes
  // are non-negative.
  localparam int X_MAX = 32767;
  localparam int X_MIN = -32768;
  localparam int P_MAX = 32767;
  localparam int P_MIN = 0;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_OUTPUT  = 2'd3
  } step_state_t;

  // One sensor measurement triple as carried on rz_data / iz_data.
  typedef struct packed {
    logic [Q_W-1:0] z3;
    logic [Q_W-1:0] z2;
    logic [Q_W-1:0] z1;
  } meas_t;

endpackage

// File: rtl/q_sat_round.sv
// Narrows one 32-bit fused lane (2*FRAC_BITS fractional bits) to 16-bit
// Q(15-FRAC_BITS).FRAC_BITS: round half up, arithmetic shift, saturate.
// Ports:
//   acc          in  ACC_W  signed fused value
//   clamp_nonneg in  1      1: saturate to [P_MIN,P_MAX], 0: [X_MIN,X_MAX]
//   q_c          out Q_W    rounded/saturated result (combinational)
module q_sat_round
  import ekf_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  logic             clamp_nonneg,
  output logic [Q_W-1:0]   q_c
);

  // One guard bit so the rounding increment cannot wrap a near-max input.
  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic [SUM_W-1:0]        RND  = SUM_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [SUM_W-1:0] X_HI = SUM_W'(X_MAX);
  localparam logic signed [SUM_W-1:0] X_LO = SUM_W'(X_MIN);
  localparam logic signed [SUM_W-1:0] P_HI = SUM_W'(P_MAX);
  localparam logic signed [SUM_W-1:0] P_LO = SUM_W'(P_MIN);

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shr;
  logic signed [SUM_W-1:0] hi;
  logic signed [SUM_W-1:0] lo;

  // Round, shift, then clip to the lane's range.
  always_comb begin
    sum = $signed({acc[ACC_W-1], acc}) + $signed(RND);
    shr = sum >>> FRAC_BITS;
    hi  = clamp_nonneg ? P_HI : X_HI;
    lo  = clamp_nonneg ? P_LO : X_LO;
    if (shr > hi) begin
      q_c = hi[Q_W-1:0];
    end else if (shr < lo) begin
      q_c = lo[Q_W-1:0];
    end else begin
      q_c = shr[Q_W-1:0];
    end
  end

endmodule

// File: rtl/ekf_step_ctrl.sv
// Sequencer and state store around the combinational dual-sensor EKF
// datapath. Collects a radar and an IR triple, holds them stable for
// SETTLE_CYCLES, captures the fused state/covariance, rounds them to Q7.8,
// feeds them back as the next prior and presents them downstream.
// Optional feature macro: EKF_STEP_TIMEOUT_EN (second-sensor timeout).
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   rz_valid/rz_ready/rz_data      radar triple handshake {z3,z2,z1}
//   iz_valid/iz_ready/iz_data      IR triple handshake {z3,z2,z1}
//   rz_hold, iz_hold               held triples to the datapath
//   x_prior, p_prior               6x16 prior state / covariance diagonal
//   xf_in, pf_in                   6x32 fused state / covariance from datapath
//   out_valid/out_ready/out_x/out_p result handshake
//   busy                           high in SETTLE, CAPTURE, OUTPUT
//   timeout_err                    one-cycle pulse on second-sensor timeout
module ekf_step_ctrl
  import ekf_pkg::*;
#(
  parameter int unsigned    SETTLE_CYCLES = 4,
  parameter int unsigned    TIMEOUT       = 1024,
  parameter int unsigned    FRAC_BITS     = 8,
  parameter logic [Q_W-1:0] X_INIT        = 16'h0000,
  parameter logic [Q_W-1:0] P_INIT        = 16'h0100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rz_valid,
  output logic              rz_ready,
  input  logic [MEAS_W-1:0] rz_data,
  input  logic              iz_valid,
  output logic              iz_ready,
  input  logic [MEAS_W-1:0] iz_data,
  output logic [MEAS_W-1:0] rz_hold,
  output logic [MEAS_W-1:0] iz_hold,
  output logic [VEC_W-1:0]  x_prior,
  output logic [VEC_W-1:0]  p_prior,
  input  logic [ACCV_W-1:0] xf_in,
  input  logic [ACCV_W-1:0] pf_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VEC_W-1:0]  out_x,
  output logic [VEC_W-1:0]  out_p,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = 8;

  // Elaboration-time parameter sanity.
  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
    $error("ekf_step_ctrl: SETTLE_CYCLES must be in 1..255");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("ekf_step_ctrl: TIMEOUT must be at least 2");
  end

  step_state_t        state_q;
  step_state_t        state_d;
  logic               rgot_q;
  logic               igot_q;
  logic               rgot_d;
  logic               igot_d;
  logic [CNT_W-1:0]   settle_cnt_q;
  logic               settle_done_c;
  logic               rz_acc_c;
  logic               iz_acc_c;
  logic               cap_c;
  logic               tmo_hit_c;
  logic               tmo_c;
  logic [VEC_W-1:0]   x_sat_c;
  logic [VEC_W-1:0]   p_sat_c;

  assign settle_done_c = (settle_cnt_q == CNT_W'(SETTLE_CYCLES - 1));

  // Rounding/saturation lanes: 6 state lanes, 6 covariance lanes.
  for (genvar i = 0; i < N_STATE; i++) begin : g_lane
    q_sat_round #(.FRAC_BITS(FRAC_BITS)) u_x_sat (
      .acc          (xf_in[i*ACC_W +: ACC_W]),
      .clamp_nonneg (1'b0),
      .q_c          (x_sat_c[i*Q_W +: Q_W])
    );
    q_sat_round #(.FRAC_BITS(FRAC_BITS)) u_p_sat (
      .acc          (pf_in[i*ACC_W +: ACC_W]),
      .clamp_nonneg (1'b1),
      .q_c          (p_sat_c[i*Q_W +: Q_W])
    );
  end

`ifdef EKF_STEP_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  logic [TCNT_W-1:0] tmo_cnt_q;

  // Counts cycles spent with exactly one sensor accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if ((rgot_q ^ igot_q) && (rgot_d ^ igot_d)) begin
      tmo_cnt_q <= tmo_cnt_q + TCNT_W'(1);
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign tmo_hit_c = (rgot_q ^ igot_q) && (tmo_cnt_q == TCNT_W'(TIMEOUT - 1));
`else
  assign tmo_hit_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (rgot_d && igot_d) state_d = ST_SETTLE;
      ST_SETTLE:  if (settle_done_c)    state_d = ST_CAPTURE;
      ST_CAPTURE:                       state_d = ST_OUTPUT;
      ST_OUTPUT:  if (out_ready)        state_d = ST_COLLECT;
      default:                          state_d = ST_COLLECT;
    endcase
  end

  // Control decode: accepts, got-flag updates, capture and timeout strobes.
  always_comb begin
    rz_acc_c = 1'b0;
    iz_acc_c = 1'b0;
    cap_c    = 1'b0;
    tmo_c    = 1'b0;
    rgot_d   = rgot_q;
    igot_d   = igot_q;
    case (state_q)
      ST_COLLECT: begin
        rz_acc_c = rz_valid && rz_ready;
        iz_acc_c = iz_valid && iz_ready;
        if (rz_acc_c) rgot_d = 1'b1;
        if (iz_acc_c) igot_d = 1'b1;
        // A second accept in the expiring cycle completes the pair instead.
        tmo_c = tmo_hit_c && !(rgot_d && igot_d);
        if (tmo_c) begin
          rgot_d = 1'b0;
          igot_d = 1'b0;
        end
      end
      ST_CAPTURE: begin
        cap_c  = 1'b1;
        rgot_d = 1'b0;
        igot_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Flags, counters, hold registers, priors and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgot_q       <= 1'b0;
      igot_q       <= 1'b0;
      settle_cnt_q <= '0;
      rz_hold      <= '0;
      iz_hold      <= '0;
      x_prior      <= {N_STATE{X_INIT}};
      p_prior      <= {N_STATE{P_INIT}};
      out_x        <= {N_STATE{X_INIT}};
      out_p        <= {N_STATE{P_INIT}};
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      rz_ready     <= 1'b1;
      iz_ready     <= 1'b1;
    end else begin
      rgot_q       <= rgot_d;
      igot_q       <= igot_d;
      settle_cnt_q <= (state_q == ST_SETTLE) ? settle_cnt_q + CNT_W'(1) : '0;
      if (rz_acc_c) rz_hold <= rz_data;
      if (iz_acc_c) iz_hold <= iz_data;
      if (cap_c) begin
        x_prior <= x_sat_c;
        p_prior <= p_sat_c;
        out_x   <= x_sat_c;
        out_p   <= p_sat_c;
      end
      out_valid   <= (state_d == ST_OUTPUT);
      busy        <= (state_d != ST_COLLECT);
      timeout_err <= tmo_c;
      // Readies are registered from the next-cycle state and flags.
      rz_ready    <= (state_d == ST_COLLECT) && !rgot_d;
      iz_ready    <= (state_d == ST_COLLECT) && !igot_d;
    end
  end

endmodule

// File: tb/tb_ekf_step_ctrl.sv
// Directed bench for ekf_step_ctrl with a result scoreboard: expected
// results are queued when a step is launched and popped by a monitor on
// each output handshake.
module tb_ekf_step_ctrl;

  localparam int SETTLE = 4;
  localparam int TMO    = 16;
  localparam int LAT    = SETTLE + 1;

  typedef struct packed {
    logic [95:0] x;
    logic [95:0] p;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rz_valid, iz_valid, out_ready;
  logic         rz_ready, iz_ready, out_valid, busy, timeout_err;
  logic [47:0]  rz_data, iz_data, rz_hold, iz_hold;
  logic [95:0]  x_prior, p_prior, out_x, out_p;
  logic [191:0] xf_in, pf_in;

  logic [191:0] xf1, pf1, xf2, pf2;
  logic [95:0]  ex1, ep1, ex2, ep2;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ekf_step_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT       (TMO),
    .FRAC_BITS     (8),
    .X_INIT        (16'h0000),
    .P_INIT        (16'h0100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rz_valid    (rz_valid),
    .rz_ready    (rz_ready),
    .rz_data     (rz_data),
    .iz_valid    (iz_valid),
    .iz_ready    (iz_ready),
    .iz_data     (iz_data),
    .rz_hold     (rz_hold),
    .iz_hold     (iz_hold),
    .x_prior     (x_prior),
    .p_prior     (p_prior),
    .xf_in       (xf_in),
    .pf_in       (pf_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_p       (out_p),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [95:0] x, input logic [95:0] p);
    exp_t e;
    e.x = x;
    e.p = p;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic r, input logic i);
    rz_valid = r;
    iz_valid = i;
    tick();
    rz_valid = 1'b0;
    iz_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_x_prior"}, x_prior, 96'h0);
    chk({tag, "_p_prior"}, p_prior, {6{16'h0100}});
    chk({tag, "_out_x"}, out_x, 96'h0);
    chk({tag, "_out_p"}, out_p, {6{16'h0100}});
    chk({tag, "_holds"}, {rz_hold, iz_hold}, 96'h0);
    chk({tag, "_flags"}, 96'({busy, out_valid, timeout_err, rz_ready, iz_ready}), 96'(5'b00011));
  endtask

  // Scoreboard monitor: compare every accepted result against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected actual=%h required=none", out_x);
        end else begin
          e = exp_q.pop_front();
          chk("mon_out_x", out_x, e.x);
          chk("mon_out_p", out_p, e.p);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;

    xf1 = {32'h0000_0080, 32'h0000_007F, 32'hFFFF_FE80, 32'h8000_0000, 32'h7FFF_0000, 32'h0000_0180};
    ex1 = {16'h0001, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0002};
    pf1 = {32'h00FF_FF80, 32'h0000_0280, 32'hFFFF_0000, 32'h8000_0000, 32'h7FFF_0000, 32'h0001_0000};
    ep1 = {16'h7FFF, 16'h0003, 16'h0000, 16'h0000, 16'h7FFF, 16'h0100};
    xf2 = {32'h0000_1734, 32'h0000_1634, 32'h0000_1534, 32'h0000_1434, 32'h0000_1334, 32'h0000_1234};
    ex2 = {16'h0017, 16'h0016, 16'h0015, 16'h0014, 16'h0013, 16'h0012};
    pf2 = {6{32'h0000_0180}};
    ep2 = {6{16'h0002}};

    rz_valid = 1'b0; iz_valid = 1'b0; out_ready = 1'b1;
    rz_data = '0; iz_data = '0;
    xf_in = xf1; pf_in = pf1;

    // Reset and idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("rst");
    rst_n = 1'b1;
    tick();
    chk_reset_values("idle");

    // Step 1: both sensors in the same cycle, rounding and saturation lanes
    rz_data = 48'h0003_0002_0001;
    iz_data = 48'h0030_0020_0010;
    push_exp(ex1, ep1);
    send(1'b1, 1'b1);
    chk("t1_holds", {rz_hold, iz_hold}, {48'h0003_0002_0001, 48'h0030_0020_0010});
    chk("t1_busy_rdy", 96'({busy, rz_ready, iz_ready}), 96'(3'b100));
    wait_valid(n);
    chk("t1_latency", 96'(n), 96'(LAT));
    chk("t1_x_prior", x_prior, ex1);
    chk("t1_p_prior", p_prior, ep1);
    tick();
    chk("t1_idle", 96'({busy, out_valid, rz_ready, iz_ready}), 96'(4'b0011));

    // Step 2: staggered accepts, then downstream backpressure
    xf_in = xf2; pf_in = pf2; out_ready = 1'b0;
    rz_data = 48'h000A_000B_000C;
    iz_data = 48'h00A0_00B0_00C0;
    push_exp(ex2, ep2);
    send(1'b1, 1'b0);
    chk("t2_rdy_radar_only", 96'({rz_ready, iz_ready, busy}), 96'(3'b010));
    chk("t2_rz_hold", 96'(rz_hold), 96'(48'h000A_000B_000C));
    tick();
    send(1'b0, 1'b1);
    chk("t2_iz_hold", 96'(iz_hold), 96'(48'h00A0_00B0_00C0));
    wait_valid(n);
    chk("t2_latency", 96'(n), 96'(LAT));
    for (int k = 0; k < 10; k++) begin
      chk("t2_stall_ctl", 96'({out_valid, rz_ready, iz_ready, busy}), 96'(4'b1001));
      chk("t2_stall_x", out_x, ex2);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t2_release", 96'({busy, out_valid, rz_ready, iz_ready}), 96'(4'b0011));
    chk("t2_x_prior", x_prior, ex2);

    // Step 3: radar only, IR withheld
    rz_data = 48'h0001_0001_0001;
    send(1'b1, 1'b0);
`ifdef EKF_STEP_TIMEOUT_EN
    n = 0;
    while (!timeout_err && n < 64) begin
      tick();
      n++;
    end
    chk("t3_tmo_seen", 96'(timeout_err), 96'd1);
    chk("t3_tmo_window", 96'((n >= TMO - 1) && (n <= TMO + 1)), 96'd1);
    tick();
    chk("t3_tmo_after", 96'({timeout_err, busy, rz_ready, iz_ready}), 96'(4'b0011));
    chk("t3_x_prior_kept", x_prior, ex2);
    chk("t3_p_prior_kept", p_prior, ep2);
`else
    pulses = 0;
    for (int k = 0; k < 3 * TMO; k++) begin
      tick();
      if (timeout_err) pulses++;
    end
    chk("t3_no_tmo", 96'(pulses), 96'd0);
    chk("t3_rdy_wait", 96'({rz_ready, iz_ready}), 96'(2'b01));
    iz_data = 48'h0002_0002_0002;
    push_exp(ex2, ep2);
    send(1'b0, 1'b1);
    wait_valid(n);
    chk("t3_latency", 96'(n), 96'(LAT));
    tick();
    chk("t3_idle", 96'({busy, out_valid, rz_ready, iz_ready}), 96'(4'b0011));
`endif

    // Step 4: reset asserted during SETTLE, then a clean step
    xf_in = xf1; pf_in = pf1;
    rz_data = 48'h0005_0006_0007;
    iz_data = 48'h0050_0060_0070;
    send(1'b1, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_values("t4_rst");
    tick();
    rst_n = 1'b1;
    tick();
    push_exp(ex1, ep1);
    send(1'b1, 1'b1);
    wait_valid(n);
    chk("t4_latency", 96'(n), 96'(LAT));
    chk("t4_x_prior", x_prior, ex1);
    tick();
    chk("t4_idle", 96'({busy, out_valid, rz_ready, iz_ready}), 96'(4'b0011));

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("queue_drained", 96'(exp_q.size()), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
